alu_seq: RTL and testbench

Parametrised, registered successor to the CPU's combinational ALU. It keeps the same 4-bit opcode map and 5-bit flag layout, and adds the following:
- an internal flags register, so ADDC/ADDCU take carry from the previous operation;
- valid/ready handshakes on input and output;
- an iterative shift-add multiplier that returns the full double-width product;
- bidirectional LSH.

It sits between the register-file read stage and write-back, and stalls the pipeline through in_ready during MULT.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_seq_mul.sv | 54 +++++
 rtl/alu_seq.sv | 164 ++++++++++++++++
 tb/tb_alu_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, flag bit positions and sequencer states for the
// registered ALU and its iterative multiplier.
package alu_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADDCU = 4'b0001;
  localparam logic [3:0] OP_OR    = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_LSH   = 4'b0100;
  localparam logic [3:0] OP_ADD   = 4'b0101;
  localparam logic [3:0] OP_ADDU  = 4'b0110;
  localparam logic [3:0] OP_ADDC  = 4'b0111;
  localparam logic [3:0] OP_CMPU  = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_NOT   = 4'b1010;
  localparam logic [3:0] OP_CMP   = 4'b1011;
  localparam logic [3:0] OP_ACCEL = 4'b1100;
  localparam logic [3:0] OP_RSVD  = 4'b1101;
  localparam logic [3:0] OP_MULT  = 4'b1110;
  localparam logic [3:0] OP_AND   = 4'b1111;

  localparam int FLG_C  = 0;
  localparam int FLG_GT = 1;
  localparam int FLG_V  = 2;
  localparam int FLG_EQ = 3;
  localparam int FLG_N  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative unsigned shift-add multiplier. The final step is presented
// combinationally on product while done is high, so the caller can latch it.
module alu_seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] mcand_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] step_sum;
  logic [WIDTH-1:0]   mplier_reg;
  logic [CW-1:0]      cnt_reg;
  logic               busy_reg;

  assign step_sum = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign busy     = busy_reg;
  assign done     = busy_reg && (cnt_reg == CW'(WIDTH - 1));
  assign product  = step_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      acc_reg    <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      acc_reg    <= '0;
      mplier_reg <= b;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= step_sum;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshakes, a persistent flags register
// and an iterative double-width multiplier.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  input  logic             flags_wr,
  input  logic [4:0]       flags_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   result_reg, result_hi_reg, alu_res;
  logic [4:0]         flags_reg, flags_base, alu_flags, mul_flags;
  logic               accept, mul_start, mul_busy, mul_done, carry_in;
  logic [2*WIDTH-1:0] mul_product;
  logic [WIDTH:0]     wide;
  logic [WIDTH-1:0]   sh_mag;
  logic               sh_neg, sh_big;

  assign in_ready   = (state_reg == ST_IDLE);
  assign out_valid  = (state_reg == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign mul_start  = accept && (op == OP_MULT) && !mul_busy;
  assign result     = result_reg;
  assign result_hi  = result_hi_reg;
  assign flags      = flags_reg;
  // A same-edge flags load forms the base; bits the op writes override it.
  assign flags_base = flags_wr ? flags_wdata : flags_reg;

  // Shift magnitude comes from the whole signed input2, so large values clear.
  assign sh_neg = input2[WIDTH-1];
  assign sh_mag = sh_neg ? (-input2) : input2;
  assign sh_big = (sh_mag >= WIDTH'(WIDTH));

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (input1),
    .b       (input2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    mul_flags        = flags_base;
    mul_flags[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    alu_res   = input1;
    alu_flags = flags_base;
    wide      = '0;
    carry_in  = 1'b0;
    case (op)
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
        carry_in = ((op == OP_ADDC) || (op == OP_ADDCU)) && flags_reg[FLG_C];
        wide     = {1'b0, input1} + {1'b0, input2} + {{WIDTH{1'b0}}, carry_in};
        alu_res  = wide[WIDTH-1:0];
        alu_flags[FLG_C] = wide[WIDTH];
        alu_flags[FLG_V] = ((op == OP_ADDU) || (op == OP_ADDCU)) ? wide[WIDTH] :
                           ((input1[WIDTH-1] == input2[WIDTH-1]) &&
                            (wide[WIDTH-1] != input1[WIDTH-1]));
        alu_flags[FLG_N] = wide[WIDTH-1];
      end
      OP_SUB: begin
        wide    = {1'b0, input1} - {1'b0, input2};
        alu_res = wide[WIDTH-1:0];
        alu_flags[FLG_C] = wide[WIDTH];
        alu_flags[FLG_V] = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                           (wide[WIDTH-1] != input1[WIDTH-1]);
        alu_flags[FLG_N] = wide[WIDTH-1];
      end
      OP_CMP: begin
        alu_flags[FLG_GT] = ($signed(input1) > $signed(input2));
        alu_flags[FLG_EQ] = (input1 == input2);
      end
      OP_CMPU: begin
        alu_flags[FLG_GT] = (input1 > input2);
        alu_flags[FLG_EQ] = (input1 == input2);
      end
      OP_AND:  alu_res = input1 & input2;
      OP_OR:   alu_res = input1 | input2;
      OP_XOR:  alu_res = input1 ^ input2;
      OP_NOT:  alu_res = ~input1;
      OP_LSH: begin
        if (sh_big) begin
          alu_res = '0;
        end else if (sh_neg) begin
          alu_res = input1 >> sh_mag[SHW-1:0];
        end else begin
          alu_res = input1 << sh_mag[SHW-1:0];
        end
      end
      OP_RSVD: alu_res = '0;
      default: alu_res = input1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = (op == OP_MULT) ? ST_MUL : ST_DONE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_reg    <= '0;
      result_hi_reg <= '0;
      flags_reg     <= '0;
    end else begin
      flags_reg <= flags_base;
      if (accept && (op != OP_MULT)) begin
        result_reg    <= alu_res;
        result_hi_reg <= '0;
        flags_reg     <= alu_flags;
      end else if ((state_reg == ST_MUL) && mul_done) begin
        result_reg    <= mul_product[WIDTH-1:0];
        result_hi_reg <= mul_product[2*WIDTH-1:WIDTH];
        flags_reg     <= mul_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] input1 = '0;
  logic [W-1:0] input2 = '0;
  logic         flags_wr = 1'b0;
  logic [4:0]   flags_wdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic [4:0]   flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .op          (op),
    .input1      (input1),
    .input2      (input2),
    .flags_wr    (flags_wr),
    .flags_wdata (flags_wdata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .result_hi   (result_hi),
    .flags       (flags)
  );

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         fwr;
    logic [4:0]   fwd;
    logic [W-1:0] er;
    logic [4:0]   ef;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic [W-1:0] rh;
    logic [4:0]   f;
  } exp_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the documented rules.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic fwr, input logic [4:0] fwd, input logic [4:0] mf);
    exp_t   e;
    longint ua, ub, sa, sb, s, ss, cin;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.r  = '0;
    e.rh = '0;
    e.f  = fwr ? fwd : mf;
    case (o)
      OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU: begin
        cin = (o == OP_ADDC || o == OP_ADDCU) ? longint'(mf[0]) : 0;
        s  = ua + ub + cin;
        ss = sa + sb + cin;
        e.r    = s[W-1:0];
        e.f[0] = (s > 65535);
        e.f[2] = (o == OP_ADD || o == OP_ADDC) ? (ss > 32767 || ss < -32768) : (s > 65535);
        e.f[4] = (s[W-1:0] >= 16'h8000);
      end
      OP_SUB: begin
        s  = ua - ub;
        ss = sa - sb;
        e.r    = s[W-1:0];
        e.f[0] = (ua < ub);
        e.f[2] = (ss > 32767 || ss < -32768);
        e.f[4] = (s[W-1:0] >= 16'h8000);
      end
      OP_CMP:   begin e.r = a; e.f[1] = (sa > sb); e.f[3] = (a == b); end
      OP_CMPU:  begin e.r = a; e.f[1] = (ua > ub); e.f[3] = (a == b); end
      OP_AND:   e.r = a & b;
      OP_OR:    e.r = a | b;
      OP_XOR:   e.r = a ^ b;
      OP_NOT:   e.r = ~a;
      OP_NOP, OP_ACCEL: e.r = a;
      OP_LSH: begin
        if (sb >= 0) e.r = (sb >= W) ? '0 : W'(ua << sb);
        else         e.r = (-sb >= W) ? '0 : W'(ua >> (-sb));
      end
      OP_MULT: begin
        s = ua * ub;
        e.r    = s[W-1:0];
        e.rh   = s[2*W-1:W];
        e.f[0] = (e.rh != 0);
      end
      default: e.r = '0;
    endcase
    return e;
  endfunction

  // Called just after a rising edge with the DUT idle; returns after the
  // result handshake. Junk is driven on the inputs while the DUT is busy.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic fwr, input logic [4:0] fwd, input int stall,
                        output logic [W-1:0] r, output logic [W-1:0] rh,
                        output logic [4:0] f, output int lat);
    check("in_ready_idle", 64'(in_ready), 64'd1);
    op = o; input1 = a; input2 = b; flags_wr = fwr; flags_wdata = fwd; in_valid = 1'b1;
    @(posedge clk); #1;
    flags_wr = 1'b0;
    op = 4'($urandom_range(0, 15)); input1 = W'($urandom); input2 = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      check("in_ready_busy", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", lat);
    end
    r = result; rh = result_hi; f = flags;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_outputs", {27'd0, result_hi, result, flags}, {27'd0, rh, r, f});
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  vec_t         vt[22];
  logic [W-1:0] r, rh;
  logic [4:0]   f, mf;
  int           lat;
  exp_t         e;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{OP_ADDU,  16'hFFFF, 16'h0001, 1'b0, 5'h00, 16'h0000, 5'h05};
    vt[1]  = '{OP_ADDC,  16'h0000, 16'h0000, 1'b0, 5'h00, 16'h0001, 5'h00};
    vt[2]  = '{OP_ADD,   16'h7FFF, 16'h0001, 1'b0, 5'h00, 16'h8000, 5'h14};
    vt[3]  = '{OP_CMP,   16'h8000, 16'h0001, 1'b0, 5'h00, 16'h8000, 5'h14};
    vt[4]  = '{OP_CMPU,  16'h8000, 16'h0001, 1'b0, 5'h00, 16'h8000, 5'h16};
    vt[5]  = '{OP_LSH,   16'h8001, 16'h0003, 1'b0, 5'h00, 16'h0008, 5'h16};
    vt[6]  = '{OP_LSH,   16'h8001, 16'hFFFF, 1'b0, 5'h00, 16'h4000, 5'h16};
    vt[7]  = '{OP_LSH,   16'h8001, 16'h0010, 1'b0, 5'h00, 16'h0000, 5'h16};
    vt[8]  = '{OP_LSH,   16'h8001, 16'hFFF0, 1'b0, 5'h00, 16'h0000, 5'h16};
    vt[9]  = '{OP_SUB,   16'h0003, 16'h0005, 1'b0, 5'h00, 16'hFFFE, 5'h13};
    vt[10] = '{OP_CMP,   16'h0005, 16'h0005, 1'b0, 5'h00, 16'h0005, 5'h19};
    vt[11] = '{OP_XOR,   16'hF0F0, 16'h0FF0, 1'b0, 5'h00, 16'hFF00, 5'h19};
    vt[12] = '{OP_NOT,   16'h1234, 16'h0000, 1'b0, 5'h00, 16'hEDCB, 5'h19};
    vt[13] = '{OP_RSVD,  16'h1234, 16'h5678, 1'b0, 5'h00, 16'h0000, 5'h19};
    vt[14] = '{OP_ADDU,  16'h0001, 16'h0001, 1'b1, 5'h1F, 16'h0002, 5'h0A};
    vt[15] = '{OP_ADDCU, 16'h8000, 16'h8000, 1'b0, 5'h00, 16'h0000, 5'h0F};
    vt[16] = '{OP_ADDCU, 16'h0001, 16'h0002, 1'b0, 5'h00, 16'h0004, 5'h0A};
    vt[17] = '{OP_AND,   16'hF0F0, 16'h3C3C, 1'b0, 5'h00, 16'h3030, 5'h0A};
    vt[18] = '{OP_OR,    16'h1200, 16'h0034, 1'b0, 5'h00, 16'h1234, 5'h0A};
    vt[19] = '{OP_ACCEL, 16'h5A5A, 16'h1111, 1'b0, 5'h00, 16'h5A5A, 5'h0A};
    vt[20] = '{OP_NOP,   16'h00AA, 16'h1111, 1'b0, 5'h00, 16'h00AA, 5'h0A};
    vt[21] = '{OP_SUB,   16'h8000, 16'h0001, 1'b0, 5'h00, 16'h7FFF, 5'h0E};

    // Asynchronous reset, observed before any clock edge
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_result_hi", 64'(result_hi), 64'd0);
    check("rst_flags", 64'(flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 22; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].fwr, vt[i].fwd, i % 3, r, rh, f, lat);
      $display("vec %0d op=%b a=%h b=%h -> result=%h hi=%h flags=%b lat=%0d",
               i, vt[i].op, vt[i].a, vt[i].b, r, rh, f, lat);
      check($sformatf("vec%0d_result", i), 64'(r), 64'(vt[i].er));
      check($sformatf("vec%0d_flags", i), 64'(f), 64'(vt[i].ef));
      check($sformatf("vec%0d_result_hi", i), 64'(rh), 64'd0);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd1);
    end
    mf = 5'h0E;

    // MULT with 5 cycles of output backpressure
    run_op(OP_MULT, 16'h1234, 16'h5678, 1'b0, 5'h00, 5, r, rh, f, lat);
    $display("mult 1234*5678 -> hi=%h lo=%h flags=%b lat=%0d", rh, r, f, lat);
    check("mult_hi", 64'(rh), 64'h0626);
    check("mult_lo", 64'(r), 64'h0060);
    check("mult_flags", 64'(f), 64'h0F);
    check("mult_latency", 64'(lat), 64'd17);
    mf = 5'h0F;

    // Reset in the middle of a MULT abandons it
    op = OP_MULT; input1 = 16'hFFFF; input2 = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #4 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result", 64'({result_hi, result}), 64'd0);
    check("abort_flags", 64'(flags), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      check("abort_no_valid", 64'(seen), 64'd0);
    end
    $display("abort mult at cycle 8 -> idle, no result");
    run_op(OP_NOP, 16'h00AA, 16'h0000, 1'b0, 5'h00, 0, r, rh, f, lat);
    $display("nop after abort -> result=%h flags=%b lat=%0d", r, f, lat);
    check("post_abort_result", 64'(r), 64'h00AA);
    check("post_abort_flags", 64'(f), 64'd0);
    mf = 5'h00;

    // Randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      logic [3:0]   o;
      logic [W-1:0] a, b;
      logic         fwr;
      logic [4:0]   fwd;
      int           mag;
      o   = 4'($urandom_range(0, 15));
      a   = W'($urandom);
      b   = W'($urandom);
      fwr = ($urandom_range(0, 3) == 0);
      fwd = 5'($urandom);
      if (o == OP_LSH) begin
        mag = int'($urandom_range(0, 20));
        b = ($urandom_range(0, 1) == 1) ? W'(mag) : W'(-mag);
      end else if ($urandom_range(0, 4) == 0) begin
        b = a;
      end
      e = model(o, a, b, fwr, fwd, mf);
      run_op(o, a, b, fwr, fwd, int'($urandom_range(0, 2)), r, rh, f, lat);
      $display("rand %0d op=%b a=%h b=%h fwr=%b -> hi=%h lo=%h flags=%b lat=%0d",
               i, o, a, b, fwr, rh, r, f, lat);
      check("rand_result", 64'(r), 64'(e.r));
      check("rand_result_hi", 64'(rh), 64'(e.rh));
      check("rand_flags", 64'(f), 64'(e.f));
      check("rand_latency", 64'(lat), (o == OP_MULT) ? 64'd17 : 64'd1);
      mf = e.f;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
